drbg_key_scheduler: RTL

- Sequences double_hash_drbg for the video scrambler.
- Runs the DRBG init handshake, then keeps a 2-entry prefetch buffer of 256-bit keys full using four-phase next_bits handshakes.
- Hands out one key per line-start request from the scrambler datapath, and forces a reseed (next_seed pulse plus re-init) every RESEED_INTERVAL keys.

---
 rtl/drbg_pkg.sv | 8 +
 rtl/key_fifo2.sv | 56 +++++
 rtl/drbg_key_scheduler.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/drbg_pkg.sv
// Shared types for the DRBG key scheduler: key width and scheduler FSM states.
package drbg_pkg;
  localparam int KEY_WIDTH = 256;

  typedef enum logic [3:0] {
    IDLE, INIT_REQ, INIT_LOW, FILL, BITS_REQ, BITS_LOW, RESEED, DRAIN, ERROR
  } state_t;
endpackage

// File: rtl/key_fifo2.sv
// Two-entry key FIFO; head is always entry 0, simultaneous push+pop keeps order.
module key_fifo2
  import drbg_pkg::*;
#(
  parameter int W = KEY_WIDTH
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         i_flush,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_din,
  output logic [W-1:0] o_head,
  output logic [1:0]   o_count
);
  logic [W-1:0] r_mem0, r_mem1;
  logic [1:0]   r_cnt;
  logic         w_pop, w_push;

  assign w_pop  = i_pop && (r_cnt != 2'd0);
  assign w_push = i_push && ((r_cnt != 2'd2) || w_pop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mem0 <= '0;
      r_mem1 <= '0;
      r_cnt  <= '0;
    end else if (i_flush) begin
      r_cnt <= '0;
    end else begin
      unique case ({w_push, w_pop})
        2'b10: begin
          if (r_cnt == 2'd0) r_mem0 <= i_din;
          else               r_mem1 <= i_din;
          r_cnt <= r_cnt + 2'd1;
        end
        2'b01: begin
          r_mem0 <= r_mem1;
          r_cnt  <= r_cnt - 2'd1;
        end
        2'b11: begin
          // Old head leaves; the new key lands behind whatever remains.
          if (r_cnt == 2'd1) r_mem0 <= i_din;
          else begin
            r_mem0 <= r_mem1;
            r_mem1 <= i_din;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_head  = r_mem0;
  assign o_count = r_cnt;
endmodule

// File: rtl/drbg_key_scheduler.sv
// Drives the DRBG init/next_bits/next_seed handshakes and hands out prefetched keys.
module drbg_key_scheduler #(
  parameter int KEY_WIDTH       = drbg_pkg::KEY_WIDTH,
  parameter int RESEED_INTERVAL = 1024,
  parameter int TIMEOUT_CYCLES  = 65535
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic                 key_req,
  output logic [KEY_WIDTH-1:0] key_out,
  output logic                 key_strobe,
  output logic                 underflow_err,
  output logic                 timeout_err,
  output logic                 busy,
  output logic [31:0]          keys_delivered,
  output logic                 drbg_init,
  input  logic                 drbg_init_ready,
  output logic                 drbg_next_bits,
  input  logic                 drbg_next_bits_ready,
  output logic                 drbg_next_seed,
  input  logic [KEY_WIDTH-1:0] drbg_random_bits
);
  import drbg_pkg::*;

  localparam int RS_W = $clog2(RESEED_INTERVAL + 1);

  state_t               r_state, w_nxt;
  logic                 r_init_rdy_q, r_bits_rdy_q;
  logic [31:0]          r_tmo_cnt;
  logic [RS_W-1:0]      r_rs_cnt;
  logic                 r_pend, r_uflow, r_tmo_err, r_strobe;
  logic [KEY_WIDTH-1:0] r_key;
  logic [31:0]          r_kd;
  logic [KEY_WIDTH-1:0] w_head;
  logic [1:0]           w_cnt;
  logic                 w_init_rise, w_bits_rise, w_tmo, w_capture, w_req, w_pop, w_flush;

  assign w_init_rise = drbg_init_ready & ~r_init_rdy_q;
  assign w_bits_rise = drbg_next_bits_ready & ~r_bits_rdy_q;
  assign w_tmo       = r_tmo_cnt >= 32'(TIMEOUT_CYCLES - 1);
  assign w_capture   = (r_state == BITS_REQ) && enable && w_bits_rise;
  assign w_req       = key_req && enable;
  // A pending request is served from the FIFO only, never bypassed from the DRBG.
  assign w_pop       = enable && (w_cnt != 2'd0) && (r_pend || w_req);
  assign w_flush     = (w_nxt == DRAIN) && (r_state != DRAIN);

  always_comb begin
    w_nxt          = r_state;
    drbg_init      = 1'b0;
    drbg_next_bits = 1'b0;
    drbg_next_seed = 1'b0;
    unique case (r_state)
      IDLE:     if (enable) w_nxt = INIT_REQ;
      INIT_REQ: begin
        drbg_init = 1'b1;
        if (w_init_rise) w_nxt = INIT_LOW;
        else if (w_tmo)  w_nxt = ERROR;
      end
      INIT_LOW: if (!drbg_init_ready) w_nxt = FILL;
                else if (w_tmo)       w_nxt = ERROR;
      FILL:     if (w_cnt < 2'd2) w_nxt = BITS_REQ;
      BITS_REQ: begin
        drbg_next_bits = 1'b1;
        if (w_bits_rise) w_nxt = BITS_LOW;
        else if (w_tmo)  w_nxt = ERROR;
      end
      BITS_LOW: if (!drbg_next_bits_ready)
                  w_nxt = (r_rs_cnt == RS_W'(RESEED_INTERVAL)) ? RESEED : FILL;
                else if (w_tmo) w_nxt = ERROR;
      RESEED: begin
        drbg_next_seed = 1'b1;
        w_nxt          = INIT_REQ;
      end
      DRAIN:    if (!drbg_init_ready && !drbg_next_bits_ready) w_nxt = IDLE;
                else if (w_tmo) w_nxt = ERROR;
      ERROR:    if (!enable) w_nxt = IDLE;
      default:  w_nxt = IDLE;
    endcase
    if (!enable && (r_state != IDLE) && (r_state != ERROR) && (r_state != DRAIN))
      w_nxt = DRAIN;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_init_rdy_q <= 1'b0;
      r_bits_rdy_q <= 1'b0;
      r_tmo_cnt    <= '0;
      r_rs_cnt     <= '0;
      r_pend       <= 1'b0;
      r_uflow      <= 1'b0;
      r_tmo_err    <= 1'b0;
      r_strobe     <= 1'b0;
      r_key        <= '0;
      r_kd         <= '0;
    end else begin
      r_state      <= w_nxt;
      r_init_rdy_q <= drbg_init_ready;
      r_bits_rdy_q <= drbg_next_bits_ready;
      if (w_nxt != r_state)       r_tmo_cnt <= '0;
      else if (r_tmo_cnt != '1)   r_tmo_cnt <= r_tmo_cnt + 32'd1;
      if (r_state == RESEED)      r_rs_cnt <= '0;
      else if (w_capture)         r_rs_cnt <= r_rs_cnt + RS_W'(1);
      r_strobe <= w_pop;
      if (w_pop) begin
        r_key <= w_head;
        r_kd  <= r_kd + 32'd1;
      end
      if (!enable) begin
        r_pend    <= 1'b0;
        r_uflow   <= 1'b0;
        r_tmo_err <= 1'b0;
      end else begin
        if (w_pop) r_pend <= 1'b0;
        else if (w_req && (w_cnt == 2'd0) && !r_pend) begin
          r_pend  <= 1'b1;
          r_uflow <= 1'b1;
        end
        if (w_nxt == ERROR) r_tmo_err <= 1'b1;
      end
    end
  end

  key_fifo2 #(.W(KEY_WIDTH)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .i_flush (w_flush),
    .i_push  (w_capture),
    .i_pop   (w_pop),
    .i_din   (drbg_random_bits),
    .o_head  (w_head),
    .o_count (w_cnt)
  );

  assign key_out        = r_key;
  assign key_strobe     = r_strobe;
  assign underflow_err  = r_uflow;
  assign timeout_err    = r_tmo_err;
  assign busy           = (r_state != IDLE) && (r_state != ERROR);
  assign keys_delivered = r_kd;
endmodule
